// File: rtl/instr_buffer.sv
// instr_buffer -- fetch/decode decoupling FIFO.
//
// Fetch pushes 0-2 {pc,inst} pairs per cycle; decode pops 0-2 per cycle.
// A flush from the pipeline controller empties the buffer, and the
// controller's issue stall freezes popping. buffer_full_o back-pressures
// fetch whenever fewer than two entries are free.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     empty the buffer (same-cycle push/pop dropped)
//   stall                     suppress pops this cycle
//   fetch_num_i               entries pushed (0..2, 3 treated as 0)
//   fetch_pc1_i/fetch_inst1_i older pushed entry (written at tail)
//   fetch_pc2_i/fetch_inst2_i younger pushed entry (written at tail+1)
//   issue_num_i               entries consumed (0..2, 3 treated as 0)
//   buffer_full_o             count > DEPTH-2
//   issue_valid_o             {count>=2, count>=1}
//   issue_pc1_o/issue_inst1_o head entry (0 when invalid)
//   issue_pc2_o/issue_inst2_o head+1 entry (0 when invalid)
//
// Optional feature, macro IBUF_PERF_CNT_EN:
//   full_cycles_o   cycles with buffer_full_o = 1
//   empty_cycles_o  cycles with count = 0 and stall = 0
//   Both clear on rst only and wrap at 2^32.

module instr_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic [1:0]        fetch_num_i,
  input  logic [DATA_W-1:0] fetch_pc1_i,
  input  logic [DATA_W-1:0] fetch_inst1_i,
  input  logic [DATA_W-1:0] fetch_pc2_i,
  input  logic [DATA_W-1:0] fetch_inst2_i,
  input  logic [1:0]        issue_num_i,
  output logic              buffer_full_o,
  output logic [1:0]        issue_valid_o,
  output logic [DATA_W-1:0] issue_pc1_o,
  output logic [DATA_W-1:0] issue_inst1_o,
  output logic [DATA_W-1:0] issue_pc2_o,
`ifdef IBUF_PERF_CNT_EN
  output logic [DATA_W-1:0] issue_inst2_o,
  output logic [31:0]       full_cycles_o,
  output logic [31:0]       empty_cycles_o
`else
  output logic [DATA_W-1:0] issue_inst2_o
`endif
);

  localparam int LANES = 2;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  // Storage is intentionally not reset; validity comes from count.
  entry_t mem_q [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [1:0] push_req, pop_req;
  logic [1:0] push_n, pop_n;

  logic   [LANES-1:0]             wr_en;
  logic   [LANES-1:0][ADDR_W-1:0] wr_idx;
  entry_t [LANES-1:0]             wr_data;
  logic   [LANES-1:0][ADDR_W-1:0] rd_idx;
  entry_t [LANES-1:0]             rd_data;

  assign buffer_full_o = (count_q > (ADDR_W+1)'(DEPTH-2));

  // Next-state for pointers and occupancy
  always_comb begin
    push_req = (fetch_num_i == 2'd3) ? 2'd0 : fetch_num_i;
    pop_req  = (issue_num_i == 2'd3) ? 2'd0 : issue_num_i;

    // Pop clamps to what is present so an empty buffer never underflows.
    pop_n = 2'd0;
    if (!stall) begin
      if ({{(ADDR_W-1){1'b0}}, pop_req} > count_q) pop_n = count_q[1:0];
      else                                         pop_n = pop_req;
    end

    // Full is judged on registered count, so a same-cycle pop never frees room.
    push_n = buffer_full_o ? 2'd0 : push_req;

    head_d  = head_q + ADDR_W'(pop_n);
    tail_d  = tail_q + ADDR_W'(push_n);
    count_d = count_q + (ADDR_W+1)'(push_n) - (ADDR_W+1)'(pop_n);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    wr_en[0]   = !rst && !flush && (push_n != 2'd0);
    wr_en[1]   = !rst && !flush && (push_n == 2'd2);
    wr_idx[0]  = tail_q;
    wr_idx[1]  = tail_q + ADDR_W'(1);
    wr_data[0] = '{pc: fetch_pc1_i, inst: fetch_inst1_i};
    wr_data[1] = '{pc: fetch_pc2_i, inst: fetch_inst2_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Two write lanes target tail and tail+1, which never collide.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr_en[l]) mem_q[wr_idx[l]] <= wr_data[l];
    end
  end

  // Zero-latency read lanes: head and head+1, masked by occupancy.
  for (genvar l = 0; l < LANES; l++) begin : g_rd
    assign rd_idx[l]        = head_q + ADDR_W'(l);
    assign issue_valid_o[l] = (count_q > (ADDR_W+1)'(l));
    assign rd_data[l]       = issue_valid_o[l] ? mem_q[rd_idx[l]] : '0;
  end

  assign issue_pc1_o   = rd_data[0].pc;
  assign issue_inst1_o = rd_data[0].inst;
  assign issue_pc2_o   = rd_data[1].pc;
  assign issue_inst2_o = rd_data[1].inst;

`ifdef IBUF_PERF_CNT_EN
  logic [31:0] full_cycles_q, full_cycles_d;
  logic [31:0] empty_cycles_q, empty_cycles_d;

  // Counters survive flush so they measure the whole run.
  always_comb begin
    full_cycles_d  = full_cycles_q  + {31'd0, buffer_full_o};
    empty_cycles_d = empty_cycles_q + {31'd0, (count_q == '0) && !stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_cycles_q  <= '0;
      empty_cycles_q <= '0;
    end else begin
      full_cycles_q  <= full_cycles_d;
      empty_cycles_q <= empty_cycles_d;
    end
  end

  assign full_cycles_o  = full_cycles_q;
  assign empty_cycles_o = empty_cycles_q;
`endif

endmodule
